// File: rtl/vector_response_checker.sv
// Response analyser for an exhaustive stimulus sweep: checks beat ordering, counts
// mismatches, captures the first failure and compacts observed outputs into a 16-bit MISR.
module vector_response_checker #(
  parameter int IN_W        = 6,
  parameter int OUT_W       = 3,
  parameter int NUM_VECTORS = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_in,
  input  logic [OUT_W-1:0] obs_out,
  input  logic [OUT_W-1:0] exp_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             seq_err,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [OUT_W-1:0] first_fail_obs,
  output logic [15:0]      signature
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0]      MISR_SEED = 16'hFFFF;
  localparam logic [15:0]      MISR_POLY = 16'h1021;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // One MISR step: CRC-CCITT style shift with the observed output folded into the low bits.
  function automatic logic [15:0] misr_next(input logic [15:0] cur, input logic [OUT_W-1:0] data);
    logic [15:0] fb;
    fb = cur[15] ? MISR_POLY : 16'h0000;
    return {cur[14:0], 1'b0} ^ fb ^ 16'(data);
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   vec_count_q, vec_count_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [CNT_W-1:0]   ff_idx_q, ff_idx_d;
  logic [OUT_W-1:0]   ff_obs_q, ff_obs_d;
  logic               seq_err_q, seq_err_d;
  logic [15:0]        sig_q, sig_d;

  logic launch_s;
  logic accept_s;
  logic mismatch_s;
  logic order_bad_s;

  assign launch_s    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accept_s    = vec_valid && (state_q == ST_RUN);
  assign mismatch_s  = (obs_out != exp_out);
  assign order_bad_s = (vec_in != vec_count_q[IN_W-1:0]);

  // Next-state and datapath update: launch clears everything, an accepted beat updates results.
  always_comb begin
    state_d     = state_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    ff_idx_d    = ff_idx_q;
    ff_obs_d    = ff_obs_q;
    seq_err_d   = seq_err_q;
    sig_d       = sig_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && (vec_count_q == LAST_IDX)) state_d = ST_DONE;
        else                                       state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch_s) begin
      vec_count_d = '0;
      err_count_d = '0;
      ff_idx_d    = '0;
      ff_obs_d    = '0;
      seq_err_d   = 1'b0;
      sig_d       = MISR_SEED;
    end else if (accept_s) begin
      vec_count_d = vec_count_q + CNT_W'(1);
      sig_d       = misr_next(sig_q, obs_out);
      // A zero error count means no mismatch has been captured yet this run.
      if (mismatch_s) begin
        if (err_count_q == '0) begin
          ff_idx_d = vec_count_q;
          ff_obs_d = obs_out;
        end else begin
          ff_idx_d = ff_idx_q;
          ff_obs_d = ff_obs_q;
        end
        if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_W'(1);
        else                        err_count_d = err_count_q;
      end else begin
        err_count_d = err_count_q;
      end
      if (order_bad_s) seq_err_d = 1'b1;
      else             seq_err_d = seq_err_q;
    end else begin
      sig_d = sig_q;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_count_q <= '0;
      err_count_q <= '0;
      ff_idx_q    <= '0;
      ff_obs_q    <= '0;
      seq_err_q   <= 1'b0;
      sig_q       <= MISR_SEED;
    end else begin
      state_q     <= state_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      ff_idx_q    <= ff_idx_d;
      ff_obs_q    <= ff_obs_d;
      seq_err_q   <= seq_err_d;
      sig_q       <= sig_d;
    end
  end

  assign vec_ready      = (state_q == ST_RUN);
  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign pass           = (state_q == ST_DONE) && (err_count_q == '0) && !seq_err_q;
  assign seq_err        = seq_err_q;
  assign vec_count      = vec_count_q;
  assign err_count      = err_count_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_obs = ff_obs_q;
  assign signature      = sig_q;

endmodule
